// File: rtl/fact_ctrl_pkg.sv
// Shared definitions for the factorial job sequencer.
//   state_t      : FSM state encodings, also published in status_reg[7:5]
//   ST_*         : bit positions inside status_reg
//   CT_*         : bit positions inside ctrl_reg
//   *_W          : widths of the status sub-fields
package fact_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  // status_reg layout
  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_DONE      = 1;
  localparam int unsigned ST_ERR       = 2;
  localparam int unsigned ST_RANGE     = 3;
  localparam int unsigned ST_TMO       = 4;
  localparam int unsigned ST_STATE_LSB = 5;
  localparam int unsigned ST_CNT_LSB   = 8;
  localparam int unsigned ST_LAT_LSB   = 16;

  // ctrl_reg layout
  localparam int unsigned CT_START = 0;
  localparam int unsigned CT_ABORT = 1;
  localparam int unsigned CT_N_LSB = 4;

  // status sub-field widths
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned JOB_CNT_W = 8;
  localparam int unsigned LAT_W     = 16;

endpackage

// File: rtl/fact_ctrl_timer.sv
// Job latency counter with saturation and timeout detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at zero (asserted in the launch cycle)
//   en         : count one wait cycle
//   lat        : wait cycles elapsed including the current one, saturating
//   tmo        : current cycle is the last one allowed before timeout
module fact_ctrl_timer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] lat,
  output logic             tmo
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // cnt holds the cycles already spent in WAIT, so the latency of a job
  // completing now is one more than that.
  always_comb begin
    lat = (cnt == '1) ? cnt : cnt + CNT_ONE;
    tmo = (cnt == TMO_LAST);
  end

endmodule

// File: rtl/fact_job_ctrl.sv
// Factorial job sequencer between the AXI register file and the datapath.
// Takes a start edge from ctrl_reg, range-checks n, launches one job, then
// waits for done/error/abort/timeout and reports the outcome.
//   sysclk, rst_n : clock, asynchronous active-low reset
//   ctrl_reg      : [0] start (edge), [1] abort (level, WAIT only), [7:4] n
//   dp_done/dp_err/dp_result : datapath completion, error, result
//   dp_go         : one-cycle launch pulse
//   dp_n          : operand, stable for the whole job
//   dp_clr        : one-cycle datapath clear on abort or timeout
//   result_reg    : last good result
//   status_reg    : busy, done, err, range_err, timeout, state, job_cnt,
//                   last_latency
//   irq           : one-cycle pulse at every job end
module fact_job_ctrl
  import fact_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_W         = 4,
  parameter int unsigned MAX_N       = 12,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ctrl_reg,
  input  logic              dp_done,
  input  logic              dp_err,
  input  logic [DATA_W-1:0] dp_result,
  output logic              dp_go,
  output logic [N_W-1:0]    dp_n,
  output logic              dp_clr,
  output logic [DATA_W-1:0] result_reg,
  output logic [DATA_W-1:0] status_reg,
  output logic              irq
);

  localparam logic [N_W-1:0]       N_LIMIT = N_W'(MAX_N);
  localparam logic [JOB_CNT_W-1:0] JOB_ONE = JOB_CNT_W'(1);

  state_t                state_q, state_d;
  logic                  start_q, start_rise;
  logic [N_W-1:0]        n_d;
  logic                  go_d, clr_d, irq_d;
  logic                  busy_q;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rng_q, rng_d;
  logic                  tmo_q, tmo_d;
  logic [JOB_CNT_W-1:0]  job_cnt_q, job_cnt_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DATA_W-1:0]     result_d;
  logic [LAT_W-1:0]      tmr_lat;
  logic                  tmr_tmo;
  logic                  ctrl_unused;

  assign ctrl_unused = ^{ctrl_reg[DATA_W-1:CT_N_LSB+N_W], ctrl_reg[CT_N_LSB-1:CT_ABORT+1]};
  assign start_rise  = ctrl_reg[CT_START] & ~start_q;

  fact_ctrl_timer #(
    .CNT_W       (LAT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk   (sysclk),
    .rst_n (rst_n),
    .clr   (state_q == S_LAUNCH),
    .en    (state_q == S_WAIT),
    .lat   (tmr_lat),
    .tmo   (tmr_tmo)
  );

  // Outputs are registered: each action is computed from the current state
  // and lands on the edge leaving it, so dp_go is high during LAUNCH and irq
  // is high in the first IDLE cycle after DONE/FAIL.
  always_comb begin
    state_d   = state_q;
    n_d       = dp_n;
    go_d      = 1'b0;
    clr_d     = 1'b0;
    irq_d     = 1'b0;
    done_d    = done_q;
    err_d     = err_q;
    rng_d     = rng_q;
    tmo_d     = tmo_q;
    job_cnt_d = job_cnt_q;
    lat_d     = lat_q;
    result_d  = result_reg;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          n_d     = ctrl_reg[CT_N_LSB +: N_W];
          done_d  = 1'b0;
          err_d   = 1'b0;
          rng_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dp_n > N_LIMIT) begin
          rng_d   = 1'b1;
          state_d = S_FAIL;
        end else begin
          go_d    = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // abort > error > done > timeout
        if (ctrl_reg[CT_ABORT]) begin
          clr_d   = 1'b1;
          state_d = S_FAIL;
        end else if (dp_err) begin
          err_d   = 1'b1;
          state_d = S_FAIL;
        end else if (dp_done) begin
          result_d = dp_result;
          lat_d    = tmr_lat;
          state_d  = S_DONE;
        end else if (tmr_tmo) begin
          tmo_d   = 1'b1;
          clr_d   = 1'b1;
          state_d = S_FAIL;
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        irq_d     = 1'b1;
        job_cnt_d = job_cnt_q + JOB_ONE;
        state_d   = S_IDLE;
      end
      S_FAIL: begin
        irq_d     = 1'b1;
        job_cnt_d = job_cnt_q + JOB_ONE;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      dp_n       <= '0;
      dp_go      <= 1'b0;
      dp_clr     <= 1'b0;
      irq        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rng_q      <= 1'b0;
      tmo_q      <= 1'b0;
      job_cnt_q  <= '0;
      lat_q      <= '0;
      result_reg <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= ctrl_reg[CT_START];
      dp_n       <= n_d;
      dp_go      <= go_d;
      dp_clr     <= clr_d;
      irq        <= irq_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= done_d;
      err_q      <= err_d;
      rng_q      <= rng_d;
      tmo_q      <= tmo_d;
      job_cnt_q  <= job_cnt_d;
      lat_q      <= lat_d;
      result_reg <= result_d;
    end
  end

  always_comb begin
    status_reg                              = '0;
    status_reg[ST_BUSY]                     = busy_q;
    status_reg[ST_DONE]                     = done_q;
    status_reg[ST_ERR]                      = err_q;
    status_reg[ST_RANGE]                    = rng_q;
    status_reg[ST_TMO]                      = tmo_q;
    status_reg[ST_STATE_LSB +: STATE_W]     = state_q;
    status_reg[ST_CNT_LSB +: JOB_CNT_W]     = job_cnt_q;
    status_reg[ST_LAT_LSB +: LAT_W]         = lat_q;
  end

endmodule

// File: tb/tb_fact_job_ctrl.sv
module tb_fact_job_ctrl;

  localparam int          TMO  = 16;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl_reg;
  logic        dp_done, dp_err;
  logic [31:0] dp_result;
  logic        dp_go, dp_clr, irq;
  logic [3:0]  dp_n;
  logic [31:0] result_reg, status_reg;

  always #5 sysclk = ~sysclk;

  fact_job_ctrl #(
    .DATA_W      (32),
    .N_W         (4),
    .MAX_N       (12),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .ctrl_reg   (ctrl_reg),
    .dp_done    (dp_done),
    .dp_err     (dp_err),
    .dp_result  (dp_result),
    .dp_go      (dp_go),
    .dp_n       (dp_n),
    .dp_clr     (dp_clr),
    .result_reg (result_reg),
    .status_reg (status_reg),
    .irq        (irq)
  );

  typedef enum int {M_DONE, M_ERR, M_TIE, M_SILENT, M_ABORT, M_ABERR} mode_t;

  typedef struct {
    int          n;
    mode_t       mode;
    int          delay;   // WAIT cycle (1-based) in which the datapath answers
    logic [31:0] dres;
    bit          poke;    // re-pulse start while the job is running
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] status;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model of the software-visible state
  logic [31:0] m_res;
  logic [7:0]  m_cnt;
  logic [15:0] m_lat;
  bit          m_done, m_err, m_rng, m_tmo;

  function automatic logic [31:0] model_status();
    return {m_lat, m_cnt, 3'd0, m_tmo, m_rng, m_err, m_done, 1'b0};
  endfunction

  function automatic logic [31:0] mk_ctrl(input bit start, input bit abort, input int n);
    logic [31:0] c;
    c      = '0;
    c[0]   = start;
    c[1]   = abort;
    c[7:4] = n[3:0];
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic model_reset();
    m_res  = '0;
    m_cnt  = '0;
    m_lat  = '0;
    m_done = 0;
    m_err  = 0;
    m_rng  = 0;
    m_tmo  = 0;
  endtask

  // Runs one job from the start edge (tick 0) for a fixed window, acting as
  // the datapath, and checks pulse timing. End-of-job state goes through the
  // scoreboard and is checked by the irq monitor.
  task automatic run_job(input vec_t v, input bit hold);
    int   go_tick, go_cnt, clr_tick, clr_cnt, irq_tick, irq_cnt, ev_tick;
    int   exp_irq, exp_clr;
    bit   rng, start_lvl, abort_now;
    exp_t e;

    go_tick = -1; go_cnt = 0; clr_tick = -1; clr_cnt = 0;
    irq_tick = -1; irq_cnt = 0; ev_tick = -1;
    rng = (v.n > 12);

    m_done = 0; m_err = 0; m_rng = 0; m_tmo = 0;
    m_cnt  = m_cnt + 8'd1;
    if (rng) m_rng = 1;
    else begin
      case (v.mode)
        M_DONE:          begin m_res = v.dres; m_lat = 16'(v.delay); m_done = 1; end
        M_ERR, M_TIE:    m_err = 1;
        M_SILENT:        m_tmo = 1;
        default:         ;
      endcase
    end
    e.res    = m_res;
    e.status = model_status();
    sb.push_back(e);

    if (rng) begin
      exp_irq = 3; exp_clr = -1;
    end else if (v.mode == M_SILENT) begin
      exp_irq = 4 + TMO; exp_clr = 3 + TMO;
    end else if (v.mode == M_ABORT || v.mode == M_ABERR) begin
      exp_irq = 4 + v.delay; exp_clr = 3 + v.delay;
    end else begin
      exp_irq = 4 + v.delay; exp_clr = -1;
    end

    start_lvl = 1;
    ctrl_reg  = mk_ctrl(1, 0, v.n);
    for (int t = 1; t <= 24; t++) begin
      tick();
      dp_done   = 0;
      dp_err    = 0;
      dp_result = JUNK;
      abort_now = 0;
      if (dp_go) begin
        go_cnt++;
        if (go_tick < 0) begin
          go_tick = t;
          ev_tick = t + v.delay;
          chk("dp_n", 32'(dp_n), 32'(v.n));
          chk("launch_state", 32'(status_reg[7:5]), 32'd2);
        end
      end
      if (dp_clr) begin
        clr_cnt++;
        if (clr_tick < 0) begin
          clr_tick = t;
          chk("clr_status", 32'(status_reg[4:0]), (v.mode == M_SILENT) ? 32'h11 : 32'h01);
        end
      end
      if (irq) begin
        irq_cnt++;
        if (irq_tick < 0) irq_tick = t;
      end
      if (t == ev_tick) begin
        case (v.mode)
          M_DONE:   begin dp_done = 1; dp_result = v.dres; end
          M_ERR:    dp_err = 1;
          M_TIE:    begin dp_done = 1; dp_err = 1; dp_result = v.dres; end
          M_ABORT:  abort_now = 1;
          M_ABERR:  begin abort_now = 1; dp_err = 1; end
          default:  ;
        endcase
      end
      if (v.poke && t == 4) start_lvl = 0;
      if (v.poke && t == 5) start_lvl = 1;
      ctrl_reg = mk_ctrl(start_lvl, abort_now, v.n);
    end

    chk("go_count", 32'(go_cnt), rng ? 32'd0 : 32'd1);
    chk("go_tick", 32'(go_tick), rng ? 32'hFFFF_FFFF : 32'd2);
    chk("clr_count", 32'(clr_cnt), (exp_clr < 0) ? 32'd0 : 32'd1);
    chk("clr_tick", 32'(clr_tick), 32'(exp_clr));
    chk("irq_count", 32'(irq_cnt), 32'd1);
    chk("irq_tick", 32'(irq_tick), 32'(exp_irq));

    if (!hold) begin
      ctrl_reg = mk_ctrl(0, 0, v.n);
      tick();
    end
  endtask

  // scoreboard consumer: every irq ends exactly one queued job
  initial begin
    exp_t e;
    forever begin
      @(posedge sysclk);
      #2;
      if (rst_n === 1'b1 && irq === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_pop: irq seen with no job queued");
        end else begin
          e = sb.pop_front();
          chk("result_reg", result_reg, e.res);
          chk("status_reg", status_reg, e.status);
        end
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  vec_t vecs[13];

  initial begin
    int cnt;

    vecs[0]  = '{5,  M_DONE,   10, 32'd120,       1'b1};
    vecs[1]  = '{13, M_DONE,   3,  32'd0,         1'b0};
    vecs[2]  = '{6,  M_ERR,    3,  32'd0,         1'b0};
    vecs[3]  = '{4,  M_TIE,    5,  32'd24,        1'b0};
    vecs[4]  = '{7,  M_DONE,   1,  32'd5040,      1'b0};
    vecs[5]  = '{12, M_DONE,   16, 32'd479001600, 1'b0};
    vecs[6]  = '{14, M_DONE,   2,  32'd0,         1'b0};
    vecs[7]  = '{0,  M_DONE,   2,  32'd1,         1'b0};
    vecs[8]  = '{2,  M_SILENT, 0,  32'd0,         1'b0};
    vecs[9]  = '{9,  M_ABORT,  4,  32'd0,         1'b0};
    vecs[10] = '{15, M_DONE,   2,  32'd0,         1'b0};
    vecs[11] = '{8,  M_ABERR,  6,  32'd0,         1'b0};
    vecs[12] = '{1,  M_ERR,    16, 32'd0,         1'b0};

    model_reset();
    rst_n     = 1'b0;
    ctrl_reg  = '0;
    dp_done   = 1'b0;
    dp_err    = 1'b0;
    dp_result = '0;
    repeat (3) tick();
    chk("rst_status", status_reg, 32'd0);
    chk("rst_result", result_reg, 32'd0);
    chk("rst_ctl", 32'({dp_go, dp_clr, irq, dp_n}), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 13; i++) run_job(vecs[i], 1'b0);

    // stray datapath pulses and a held abort while idle change nothing
    cnt       = 0;
    ctrl_reg  = mk_ctrl(0, 1, 5);
    dp_done   = 1'b1;
    dp_err    = 1'b1;
    dp_result = JUNK;
    for (int t = 0; t < 3; t++) begin
      tick();
      cnt += int'(dp_go) + int'(dp_clr) + int'(irq);
    end
    chk("idle_pulses", 32'(cnt), 32'd0);
    chk("idle_status", status_reg, model_status());
    chk("idle_result", result_reg, m_res);
    ctrl_reg = '0;
    dp_done  = 1'b0;
    dp_err   = 1'b0;
    tick();

    // start held high past job end must not relaunch; a fresh edge must
    run_job('{2, M_DONE, 3, 32'd2, 1'b0}, 1'b1);
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      cnt += int'(dp_go);
    end
    chk("held_start_go", 32'(cnt), 32'd0);
    chk("held_start_busy", 32'(status_reg[0]), 32'd0);
    ctrl_reg = '0;
    tick();
    run_job('{6, M_DONE, 5, 32'd720, 1'b0}, 1'b0);

    // asynchronous reset in the middle of WAIT
    ctrl_reg = mk_ctrl(1, 0, 3);
    repeat (6) tick();
    chk("pre_rst_state", 32'(status_reg[7:5]), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_status", status_reg, 32'd0);
    chk("async_rst_result", result_reg, 32'd0);
    chk("async_rst_ctl", 32'({dp_go, dp_clr, irq, dp_n}), 32'd0);
    ctrl_reg = '0;
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    run_job('{3, M_DONE, 4, 32'd6, 1'b0}, 1'b0);

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
